// File: rtl/control_mc_v2_pkg.sv
// Shared constants for the multicycle control unit: opcodes, state codes, mux encodings,
// trap codes and small decode helpers.
package control_mc_v2_pkg;

  // Opcodes with fixed meaning; R-type and I-type are ranges decoded in decode_next().
  localparam logic [5:0] OpNop  = 6'b000000;
  localparam logic [5:0] OpJump = 6'b000001;
  localparam logic [5:0] OpJal  = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b100000;
  localparam logic [5:0] OpBne  = 6'b100001;
  localparam logic [5:0] OpLi   = 6'b111001;
  localparam logic [5:0] OpLwi  = 6'b111011;
  localparam logic [5:0] OpSwi  = 6'b111100;
  localparam logic [5:0] OpHalt = 6'b111111;

  // FSM state codes.
  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StExecR  = 4'd2;
  localparam logic [3:0] StExecI  = 4'd3;
  localparam logic [3:0] StAluWb  = 4'd4;
  localparam logic [3:0] StAddr   = 4'd5;
  localparam logic [3:0] StMemRd  = 4'd6;
  localparam logic [3:0] StLdWb   = 4'd7;
  localparam logic [3:0] StMemWr  = 4'd8;
  localparam logic [3:0] StLiWb   = 4'd9;
  localparam logic [3:0] StBr     = 4'd10;
  localparam logic [3:0] StJump   = 4'd11;
  localparam logic [3:0] StJal    = 4'd12;
  localparam logic [3:0] StHalt   = 4'd13;
  localparam logic [3:0] StTrap   = 4'd14;

  // Write-back source.
  localparam logic [1:0] M2rAlu = 2'b00;
  localparam logic [1:0] M2rMdr = 2'b01;
  localparam logic [1:0] M2rImm = 2'b10;
  localparam logic [1:0] M2rPc  = 2'b11;

  // PC source.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU B operand.
  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBSext = 2'b10;
  localparam logic [1:0] SrcBZext = 2'b11;

  // Trap codes.
  localparam logic [1:0] TrapNone    = 2'b00;
  localparam logic [1:0] TrapIllegal = 2'b01;
  localparam logic [1:0] TrapTimeout = 2'b10;

  // ALU functions used directly by the FSM.
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0011;

  // State following DECODE for a given opcode; unknown opcodes go to TRAP.
  function automatic logic [3:0] decode_next(input logic [5:0] op);
    logic [3:0] st;
    st = StTrap;
    if (op == OpNop) begin
      st = StFetch;
    end else if (op[5:3] == 3'b010) begin
      st = StExecR;
    end else if (op[5:3] == 3'b110 && op[2:0] >= 3'b010) begin
      st = StExecI;
    end else if (op == OpLi || op == OpLwi || op == OpSwi) begin
      st = StAddr;
    end else if (op == OpBeq || op == OpBne) begin
      st = StBr;
    end else if (op == OpJump) begin
      st = StJump;
    end else if (op == OpJal) begin
      st = StJal;
    end else if (op == OpHalt) begin
      st = StHalt;
    end
    return st;
  endfunction

  // Arithmetic immediates (add, sub, slt) are sign-extended; logical ones zero-extended.
  function automatic logic [1:0] imm_src_b(input logic [3:0] fn);
    return (fn == 4'b0010 || fn == 4'b0011 || fn == 4'b0111) ? SrcBSext : SrcBZext;
  endfunction

  // States that wait on the memory handshake.
  function automatic logic is_mem_state(input logic [3:0] st);
    return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
  endfunction

endpackage

// File: rtl/control_mc_v2_if.sv
// Control bus between the control FSM (master) and the datapath (slave).
interface control_mc_v2_if #(
  parameter int unsigned ALUOP_W = 4
) ();

  logic [5:0]         op;
  logic               mem_ready;
  logic               PCWriteCond;
  logic               branch_ne;
  logic               PCWrite;
  logic               MemRead;
  logic               MemWrite;
  logic [1:0]         MemtoReg;
  logic               IRWrite;
  logic [1:0]         PCSource;
  logic [ALUOP_W-1:0] ALUOp;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               RegWrite;
  logic               RegDst;
  logic               halted;
  logic [1:0]         trap;

  modport master (
    input  op, mem_ready,
    output PCWriteCond, branch_ne, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
           ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, halted, trap
  );

  modport slave (
    output op, mem_ready,
    input  PCWriteCond, branch_ne, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
           ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, halted, trap
  );

endinterface

// File: rtl/control_mc_v2_wait_timer.sv
// Memory wait-state counter: counts consecutive stalled cycles and flags the last allowed one.
module control_mc_v2_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic timeout
);

  localparam int unsigned CntW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_MAX - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Any non-stalled cycle (ready, or outside a memory state) clears the count.
  always_comb begin
    cnt_d = '0;
    if (count_en && cnt_q != LastCnt) begin
      cnt_d = cnt_q + 1'b1;
    end else if (count_en) begin
      cnt_d = cnt_q;
    end
  end

  // Fires on the WAIT_MAX-th consecutive stalled cycle.
  assign timeout = count_en && (cnt_q == LastCnt);

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_mc_v2.sv
// Multicycle CPU control FSM with memory wait-state timeout, branch/jump/jal/halt and traps.
module control_mc_v2 #(
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic            clk,
  input logic            reset,
  control_mc_v2_if.master bus
);

  import control_mc_v2_pkg::*;

  logic [3:0] state_q, state_d;
  logic [1:0] trap_q, trap_d;
  logic       ready_eff;
  logic       wait_en;
  logic       wait_timeout;

  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic       branch_ne, alu_src_a, reg_dst;
  logic [1:0] mem_to_reg, pc_source, alu_src_b;
  logic [3:0] alu_fn;

  assign ready_eff = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;
  assign wait_en   = is_mem_state(state_q) && !ready_eff;

  control_mc_v2_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .count_en(wait_en),
    .timeout (wait_timeout)
  );

  // Next state and sticky trap code.
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    case (state_q)
      StFetch, StMemWr: begin
        if (ready_eff) begin
          state_d = StDecode;
          if (state_q == StMemWr) state_d = StFetch;
        end else if (wait_timeout) begin
          state_d = StTrap;
          trap_d  = TrapTimeout;
        end
      end
      StMemRd: begin
        if (ready_eff) begin
          state_d = StLdWb;
        end else if (wait_timeout) begin
          state_d = StTrap;
          trap_d  = TrapTimeout;
        end
      end
      StDecode: begin
        state_d = decode_next(bus.op);
        if (state_d == StTrap) trap_d = TrapIllegal;
      end
      StExecR, StExecI: state_d = StAluWb;
      StAddr: begin
        if (bus.op == OpLwi) begin
          state_d = StMemRd;
        end else if (bus.op == OpSwi) begin
          state_d = StMemWr;
        end else begin
          state_d = StLiWb;
        end
      end
      StAluWb, StLdWb, StLiWb, StBr, StJump, StJal: state_d = StFetch;
      StHalt, StTrap: state_d = state_q;
      default: state_d = StFetch;
    endcase
  end

  // Control outputs decoded from the registered state; only FETCH uses mem_ready directly.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    branch_ne     = 1'b0;
    mem_to_reg    = M2rAlu;
    pc_source     = PcSrcAlu;
    alu_fn        = AluAdd;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBFour;
    reg_dst       = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        pc_write = ready_eff;
        ir_write = ready_eff;
      end
      StDecode, StAddr: alu_src_b = SrcBSext;
      // ALU_WB keeps the exec operands so ALUOut stays stable while it is written back.
      StExecR, StExecI, StAluWb: begin
        alu_src_a = 1'b1;
        alu_src_b = bus.op[5] ? imm_src_b(bus.op[3:0]) : SrcBReg;
        alu_fn    = bus.op[3:0];
        if (state_q == StAluWb) begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          mem_to_reg = M2rAlu;
        end
      end
      StMemRd: mem_read = 1'b1;
      StLdWb: begin
        reg_write  = 1'b1;
        mem_to_reg = M2rMdr;
      end
      StMemWr: mem_write = 1'b1;
      StLiWb: begin
        reg_write  = 1'b1;
        mem_to_reg = M2rImm;
      end
      StBr: begin
        pc_write_cond = 1'b1;
        pc_source     = PcSrcAluOut;
        alu_src_a     = 1'b1;
        alu_src_b     = SrcBReg;
        alu_fn        = AluSub;
        branch_ne     = bus.op[0];
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PcSrcJump;
      end
      StJal: begin
        pc_write   = 1'b1;
        pc_source  = PcSrcJump;
        reg_write  = 1'b1;
        mem_to_reg = M2rPc;
        reg_dst    = 1'b0;
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so an in-flight access is cut off without waiting for a clock.
  assign bus.PCWrite     = pc_write & reset;
  assign bus.PCWriteCond = pc_write_cond & reset;
  assign bus.IRWrite     = ir_write & reset;
  assign bus.MemRead     = mem_read & reset;
  assign bus.MemWrite    = mem_write & reset;
  assign bus.RegWrite    = reg_write & reset;
  assign bus.branch_ne   = branch_ne;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.PCSource    = pc_source;
  assign bus.ALUOp       = ALUOP_W'(alu_fn);
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.RegDst      = reg_dst;
  assign bus.halted      = (state_q == StHalt);
  assign bus.trap        = trap_q;

  // State and trap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      trap_q  <= TrapNone;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_control_mc_v2.sv
// Self-checking bench for control_mc_v2: directed scenarios plus a random instruction stream
// checked against a per-instruction phase model.
module tb_control_mc_v2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  control_mc_v2_if #(.ALUOP_W(4)) bus ();

  control_mc_v2 #(
    .ALUOP_W (4),
    .MEM_WAIT(1),
    .WAIT_MAX(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] en;     // PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite
    logic [1:0] m2r;
    logic [1:0] pcs;
    logic       sa;
    logic [1:0] sb;
    logic [3:0] aop;
    logic       rd;
    logic       bne;
    logic [1:0] trap;
    logic       halted;
  } obs_t;

  function automatic obs_t sample();
    obs_t s;
    s.en     = {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.MemRead, bus.MemWrite,
                bus.RegWrite};
    s.m2r    = bus.MemtoReg;
    s.pcs    = bus.PCSource;
    s.sa     = bus.ALUSrcA;
    s.sb     = bus.ALUSrcB;
    s.aop    = bus.ALUOp[3:0];
    s.rd     = bus.RegDst;
    s.bne    = bus.branch_ne;
    s.trap   = bus.trap;
    s.halted = bus.halted;
    return s;
  endfunction

  // Expected outputs for one instruction phase, with a mask of the fields that matter there.
  function automatic void expect_phase(input byte ph, input logic [5:0] o, input logic r,
                                       output obs_t e, output obs_t c);
    e = '0;
    c = '0;
    c.en = '1;
    c.trap = '1;
    c.halted = 1'b1;
    case (ph)
      "F": begin
        e.en = {r, 1'b0, r, 1'b1, 1'b0, 1'b0};
        c.pcs = '1; c.sa = 1'b1; c.sb = '1; c.aop = '1;
        e.pcs = 2'b00; e.sa = 1'b0; e.sb = 2'b01; e.aop = 4'b0010;
      end
      "D", "A": begin
        c.sb = '1; c.aop = '1;
        e.sb = 2'b10; e.aop = 4'b0010;
      end
      "X", "W": begin
        c.sa = 1'b1; c.sb = '1; c.aop = '1;
        e.sa = 1'b1;
        e.aop = o[3:0];
        if (!o[5]) e.sb = 2'b00;
        else if (o[3:0] == 4'd2 || o[3:0] == 4'd3 || o[3:0] == 4'd7) e.sb = 2'b10;
        else e.sb = 2'b11;
        if (ph == "W") begin
          e.en = 6'b000001;
          c.m2r = '1; c.rd = 1'b1;
          e.m2r = 2'b00; e.rd = 1'b1;
        end
      end
      "R": e.en = 6'b000100;
      "L": begin
        e.en = 6'b000001; c.m2r = '1; e.m2r = 2'b01;
      end
      "S": e.en = 6'b000010;
      "I": begin
        e.en = 6'b000001; c.m2r = '1; e.m2r = 2'b10;
      end
      "B": begin
        e.en = 6'b010000;
        c.pcs = '1; c.sa = 1'b1; c.sb = '1; c.aop = '1; c.bne = 1'b1;
        e.pcs = 2'b01; e.sa = 1'b1; e.sb = 2'b00; e.aop = 4'b0011; e.bne = o[0];
      end
      "J": begin
        e.en = 6'b100000; c.pcs = '1; e.pcs = 2'b10;
      end
      "K": begin
        e.en = 6'b100001;
        c.pcs = '1; c.m2r = '1; c.rd = 1'b1;
        e.pcs = 2'b10; e.m2r = 2'b11; e.rd = 1'b0;
      end
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.op = 6'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t a;
    reset = 1'b0;
    bus.op = 6'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    a = sample();
    total++;
    if (a.en !== 6'b0) begin
      bad++; $display("FAIL reset_enables got=%b want=000000", a.en);
    end
    total++;
    if ({a.sa, a.sb, a.aop, a.pcs, a.m2r, a.rd} !== {1'b0, 2'b01, 4'b0010, 2'b00, 2'b00, 1'b0})
    begin
      bad++; $display("FAIL reset_muxes got sa=%b sb=%b aop=%b pcs=%b m2r=%b rd=%b", a.sa, a.sb,
                      a.aop, a.pcs, a.m2r, a.rd);
    end
    total++;
    if ({a.trap, a.halted} !== 3'b000) begin
      bad++; $display("FAIL reset_status got trap=%b halted=%b want 00/0", a.trap, a.halted);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    a = sample();
    total++;
    if (a.en !== 6'b000100) begin
      bad++; $display("FAIL reset_release_fetch got=%b want=000100", a.en);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    obs_t a;
    do_reset();
    bus.op = 6'b111100;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.MemWrite !== 1'b1) begin
      bad++; $display("FAIL midwr_active got=%b want=1", bus.MemWrite);
    end
    #2;
    reset = 1'b0;
    #1;
    a = sample();
    total++;
    if (a.en !== 6'b0) begin
      bad++; $display("FAIL midwr_async_abort got=%b want=000000", a.en);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    a = sample();
    total++;
    if ({a.en, a.sb, a.sa} !== {6'b000100, 2'b01, 1'b0}) begin
      bad++; $display("FAIL midwr_refetch got en=%b sb=%b sa=%b want 000100/01/0", a.en, a.sb,
                      a.sa);
    end
    @(negedge clk);
  endtask

  task automatic test_rtype();
    do_reset();
    bus.op = 6'b010011;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if (bus.RegWrite !== (cyc == 4)) begin
        bad++; $display("FAIL rtype_regwrite cyc=%0d got=%b want=%b", cyc, bus.RegWrite, cyc == 4);
      end
      if (cyc == 3 || cyc == 4) begin
        total++;
        if (bus.ALUOp !== 4'b0011) begin
          bad++; $display("FAIL rtype_aluop cyc=%0d got=%b want=0011", cyc, bus.ALUOp);
        end
      end
      if (cyc == 5) begin
        total++;
        if ({bus.IRWrite, bus.MemRead} !== 2'b11) begin
          bad++; $display("FAIL rtype_refetch got=%b want=11", {bus.IRWrite, bus.MemRead});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lwi_wait();
    logic exp_rd, exp_wr;
    do_reset();
    bus.op = 6'b111011;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      bus.mem_ready = !(cyc >= 4 && cyc <= 6);
      exp_rd = (cyc == 1) || (cyc >= 4 && cyc <= 7) || (cyc == 9);
      exp_wr = (cyc == 8);
      #1;
      total++;
      if ({bus.MemRead, bus.RegWrite} !== {exp_rd, exp_wr}) begin
        bad++; $display("FAIL lwi_wait cyc=%0d got rd=%b wr=%b want rd=%b wr=%b", cyc,
                        bus.MemRead, bus.RegWrite, exp_rd, exp_wr);
      end
      if (cyc == 8) begin
        total++;
        if (bus.MemtoReg !== 2'b01) begin
          bad++; $display("FAIL lwi_memtoreg got=%b want=01", bus.MemtoReg);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    obs_t a;
    do_reset();
    for (int cyc = 1; cyc <= 15; cyc++) begin
      bus.mem_ready = 1'b0;
      #1;
      total++;
      if ({bus.IRWrite, bus.trap} !== 3'b000) begin
        bad++; $display("FAIL timeout_wait cyc=%0d got ir=%b trap=%b want 0/00", cyc,
                        bus.IRWrite, bus.trap);
      end
      @(negedge clk);
    end
    for (int cyc = 16; cyc <= 19; cyc++) begin
      bus.mem_ready = (cyc > 16);
      #1;
      a = sample();
      total++;
      if ({a.trap, a.en} !== {2'b10, 6'b0}) begin
        bad++; $display("FAIL timeout_trap cyc=%0d got trap=%b en=%b want 10/000000", cyc,
                        a.trap, a.en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    for (int cyc = 1; cyc <= 17; cyc++) begin
      bus.mem_ready = (cyc >= 15);
      #1;
      if (cyc == 15) begin
        total++;
        if ({bus.IRWrite, bus.trap} !== 3'b100) begin
          bad++; $display("FAIL timeout_edge_ready got ir=%b trap=%b want 1/00", bus.IRWrite,
                          bus.trap);
        end
      end else if (cyc == 17) begin
        total++;
        if ({bus.MemRead, bus.trap} !== 3'b100) begin
          bad++; $display("FAIL timeout_edge_refetch got rd=%b trap=%b want 1/00", bus.MemRead,
                          bus.trap);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2];
    ops[0] = 6'b100000;
    ops[1] = 6'b100001;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.op = ops[k];
      for (int cyc = 1; cyc <= 4; cyc++) begin
        bus.mem_ready = 1'b1;
        #1;
        if (cyc == 3) begin
          total++;
          if ({bus.PCWriteCond, bus.branch_ne, bus.PCSource} !== {1'b1, ops[k][0], 2'b01}) begin
            bad++; $display("FAIL branch op=%b got cond=%b ne=%b pcs=%b want 1/%b/01", ops[k],
                            bus.PCWriteCond, bus.branch_ne, bus.PCSource, ops[k][0]);
          end
        end else if (cyc == 4) begin
          total++;
          if (bus.IRWrite !== 1'b1) begin
            bad++; $display("FAIL branch_return op=%b got ir=%b want 1", ops[k], bus.IRWrite);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal_and_halt();
    obs_t a;
    do_reset();
    bus.op = 6'b101010;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      bus.mem_ready = (cyc <= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      a = sample();
      if (cyc == 2) begin
        total++;
        if (a.trap !== 2'b00) begin
          bad++; $display("FAIL illegal_early got trap=%b want 00", a.trap);
        end
      end else if (cyc >= 3) begin
        total++;
        if ({a.trap, a.en, a.halted} !== {2'b01, 6'b0, 1'b0}) begin
          bad++; $display("FAIL illegal_trap cyc=%0d got trap=%b en=%b halted=%b", cyc, a.trap,
                          a.en, a.halted);
        end
      end
      @(negedge clk);
    end
    do_reset();
    bus.op = 6'b111111;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      bus.mem_ready = (cyc <= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      a = sample();
      if (cyc >= 3) begin
        total++;
        if ({a.halted, a.trap, a.en} !== {1'b1, 2'b00, 6'b0}) begin
          bad++; $display("FAIL halt cyc=%0d got halted=%b trap=%b en=%b", cyc, a.halted,
                          a.trap, a.en);
        end
      end
      @(negedge clk);
    end
  endtask

  // Random back-to-back instruction stream with random memory wait states.
  task automatic test_random_program(input int n);
    logic [5:0] o;
    string      seq;
    byte        p;
    logic       w, r;
    int         target;
    obs_t       a, e, c;
    do_reset();
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0: begin o = 6'b000000; seq = "FD"; end
        1: begin o = {3'b010, 3'($urandom_range(0, 7))}; seq = "FDXW"; end
        2: begin o = 6'(6'b110010 + $urandom_range(0, 5)); seq = "FDXW"; end
        3: begin o = 6'b111011; seq = "FDARL"; end
        4: begin o = 6'b111100; seq = "FDAS"; end
        5: begin o = 6'b111001; seq = "FDAI"; end
        6: begin o = 6'b100000; seq = "FDB"; end
        7: begin o = 6'b100001; seq = "FDB"; end
        8: begin o = 6'b000001; seq = "FDJ"; end
        default: begin o = 6'b000010; seq = "FDK"; end
      endcase
      bus.op = o;
      for (int i = 0; i < seq.len(); i++) begin
        p = seq[i];
        w = (p == "F") || (p == "R") || (p == "S");
        target = w ? $urandom_range(0, 3) : 0;
        for (int g = 0; g <= target; g++) begin
          r = w ? (g == target) : 1'($urandom_range(0, 1));
          bus.mem_ready = r;
          #1;
          a = sample();
          expect_phase(p, o, r, e, c);
          total++;
          if ((a & c) !== (e & c)) begin
            bad++; $display("FAIL program instr=%0d op=%b phase=%c got=%h want=%h mask=%h", k, o,
                            p, a, e, c);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.op = 6'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_reset_mid_write();
    test_rtype();
    test_lwi_wait();
    test_branch();
    test_timeout();
    test_timeout_boundary();
    test_illegal_and_halt();
    test_random_program(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
